// File: rtl/xclk_pkg.sv
// Shared types and sizing helpers for the camera master-clock controller.
// Pure declarations; no logic, latency or flow control of its own.
package xclk_pkg;

    typedef enum logic [1:0] {
        STOPPED,
        RUNNING,
        STOPPING
    } xclk_state_t;

    localparam int DEF_SETTLE_RISES = 16;
    localparam int SETTLE_W         = $clog2(DEF_SETTLE_RISES + 1);

    function automatic int settle_w(input int rises);
        return $clog2(rises + 1);
    endfunction

endpackage

// File: rtl/xclk_if.sv
// Control/status bundle between the XCLK controller and its requester (enable, divisor handshake, clock out).
// Wires only; the divisor request is a level req answered by a one-cycle ack, held off while a value is pending.
interface xclk_if #(
    parameter int DIV_W = 8
);
    logic             i_enable;
    logic             i_div_req;
    logic [DIV_W-1:0] i_div_val;
    logic             o_div_ack;
    logic             o_div_err;
    logic             o_clk;
    logic             o_rise;
    logic             o_fall;
    logic             o_ready;

    modport master (
        output i_enable, i_div_req, i_div_val,
        input  o_div_ack, o_div_err, o_clk, o_rise, o_fall, o_ready
    );

    modport slave (
        input  i_enable, i_div_req, i_div_val,
        output o_div_ack, o_div_err, o_clk, o_rise, o_fall, o_ready
    );
endinterface

// File: rtl/half_period_cnt.sv
// Half-period divider: toggles clk_q every div cycles while run, with registered rise/fall flags.
// Flags and clk_q update on the same edge; load or !run parks the count at 1 without toggling.
module half_period_cnt #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             clk_q,
    output logic             rise,
    output logic             fall,
    output logic             toggle
);

    logic [DIV_W-1:0] cnt;

    // Combinational so the controller can act on the same edge that flips clk_q.
    assign toggle = run && !load && (cnt == div);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= DIV_W'(1);
            clk_q <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= toggle && !clk_q;
            fall <= toggle && clk_q;
            if (toggle) begin
                clk_q <= !clk_q;
                cnt   <= DIV_W'(1);
            end else if (run && !load) begin
                cnt <= cnt + DIV_W'(1);
            end else begin
                cnt <= DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/xclk_ctrl.sv
// Camera XCLK controller: glitch-free start/stop, divisor updates on period boundaries, settle-based o_ready.
// Registered outputs; ack one cycle after a request is sampled, withheld while a divisor is still pending.
module xclk_ctrl
    import xclk_pkg::*;
#(
    parameter int DIV_W        = 8,
    parameter int DEFAULT_DIV  = 4,
    parameter int SETTLE_RISES = DEF_SETTLE_RISES
) (
    input logic   clk,
    input logic   rst,
    xclk_if.slave bus
);

    localparam int SW = settle_w(SETTLE_RISES);

    xclk_state_t      state, state_nxt;
    logic [DIV_W-1:0] div, pend_div;
    logic             pend_vld;
    logic [SW-1:0]    settle, settle_nxt;
    logic             ack_q, err_q, ready_q;
    logic             run, load, toggle;
    logic             clk_q, rise_q, fall_q;
    logic             rise_evt, fall_evt, apply, accept;

    half_period_cnt #(.DIV_W(DIV_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .load   (load),
        .div    (div),
        .clk_q  (clk_q),
        .rise   (rise_q),
        .fall   (fall_q),
        .toggle (toggle)
    );

    assign run      = (state != STOPPED);
    // Stopping while already low: park the counter so no rise can slip out.
    assign load     = (state == RUNNING) && !bus.i_enable && !clk_q;
    assign rise_evt = toggle && !clk_q;
    assign fall_evt = toggle && clk_q;
    assign apply    = pend_vld && ((state == STOPPED) || fall_evt);
    assign accept   = bus.i_div_req && !pend_vld;

    always_comb begin
        state_nxt = state;
        case (state)
            STOPPED:  if (bus.i_enable) state_nxt = RUNNING;
            RUNNING:  if (!bus.i_enable) state_nxt = (!clk_q || fall_evt) ? STOPPED : STOPPING;
            STOPPING: begin
                if (bus.i_enable)  state_nxt = RUNNING;
                else if (fall_evt) state_nxt = STOPPED;
            end
            default:  state_nxt = STOPPED;
        endcase
    end

    always_comb begin
        settle_nxt = settle;
        if (((state_nxt == STOPPED) && (state != STOPPED)) || apply)
            settle_nxt = '0;
        else if (rise_evt && (settle != SW'(SETTLE_RISES)))
            settle_nxt = settle + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= STOPPED;
            div      <= DIV_W'(DEFAULT_DIV);
            pend_div <= '0;
            pend_vld <= 1'b0;
            settle   <= '0;
            ready_q  <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            settle  <= settle_nxt;
            ready_q <= (settle_nxt >= SW'(SETTLE_RISES));
            ack_q   <= accept;
            err_q   <= accept && (bus.i_div_val == '0);
            if (apply) begin
                div      <= pend_div;
                pend_vld <= 1'b0;
            end
            // accept and apply are mutually exclusive: one needs pending empty, the other full.
            if (accept && (bus.i_div_val != '0)) begin
                pend_div <= bus.i_div_val;
                pend_vld <= 1'b1;
            end
        end
    end

    assign bus.o_div_ack = ack_q;
    assign bus.o_div_err = err_q;
    assign bus.o_clk     = clk_q;
    assign bus.o_rise    = rise_q;
    assign bus.o_fall    = fall_q;
    assign bus.o_ready   = ready_q;

endmodule

// File: tb/tb_xclk_ctrl.sv
// Bench for xclk_ctrl: timestamp-based reference model checked every cycle, plus literal waveform checkpoints.
module tb_xclk_ctrl;

    logic clk;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    int   now   = 0;
    bit   cmp_en = 0;

    xclk_if #(.DIV_W(8)) bus ();

    xclk_ctrl #(.DIV_W(8), .DEFAULT_DIV(4), .SETTLE_RISES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %b expected %b", nm, now, act, exp);
        end
    endtask

    // Reference model: output level changes at absolute cycle stamps, divisor
    // changes ride on falling edges, ready counts rises since the last clear.
    bit m_clk, m_rise, m_fall, m_ready, m_ack, m_err;
    bit m_act;
    int m_cyc, m_edge_at, m_div, m_rises;
    int pend_q[$];

    task automatic model_step();
        int  c;
        bit  en, lvl_p, act_p, pend_p, clr, applied;
        if (rst) begin
            m_cyc = 0; m_act = 0; m_clk = 0; m_rise = 0; m_fall = 0;
            m_div = 4; m_rises = 0; m_ready = 0; m_ack = 0; m_err = 0;
            m_edge_at = 0;
            pend_q.delete();
            return;
        end
        c = m_cyc + 1;
        en = bus.i_enable;
        lvl_p = m_clk;
        act_p = m_act;
        pend_p = (pend_q.size() != 0);
        clr = 0;
        applied = 0;
        m_rise = 0;
        m_fall = 0;
        m_ack = bus.i_div_req && !pend_p;
        m_err = m_ack && (bus.i_div_val == 8'd0);
        if (act_p && !en && !lvl_p) begin
            m_act = 0;
            clr = 1;
        end else if (act_p && (m_edge_at == c)) begin
            m_clk = !lvl_p;
            if (m_clk) begin
                m_rise = 1;
            end else begin
                m_fall = 1;
                if (pend_p) begin m_div = pend_q.pop_front(); applied = 1; end
                if (!en) begin m_act = 0; clr = 1; end
            end
            m_edge_at = c + m_div;
        end else if (!act_p) begin
            if (pend_p) begin m_div = pend_q.pop_front(); applied = 1; end
            if (en) begin m_act = 1; m_edge_at = c + m_div; end
        end
        if (m_ack && (bus.i_div_val != 8'd0)) pend_q.push_back(int'(bus.i_div_val));
        if (clr || applied)                m_rises = 0;
        else if (m_rise && m_rises < 16)   m_rises++;
        m_ready = (m_rises >= 16);
        m_cyc = c;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("cmp_clk",   bus.o_clk,     m_clk);
            chk("cmp_rise",  bus.o_rise,    m_rise);
            chk("cmp_fall",  bus.o_fall,    m_fall);
            chk("cmp_ready", bus.o_ready,   m_ready);
            chk("cmp_ack",   bus.o_div_ack, m_ack);
            chk("cmp_err",   bus.o_div_err, m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        now++;
    endtask

    task automatic run_to(input int n);
        while (now < n) tick();
    endtask

    task automatic req(input logic r, input logic [7:0] v);
        bus.i_div_req = r;
        bus.i_div_val = v;
    endtask

    initial begin
        rst = 1'b1;
        bus.i_enable = 1'b0;
        req(1'b0, 8'd0);
        repeat (3) tick();
        chk("rst_clk",   bus.o_clk,     1'b0);
        chk("rst_rise",  bus.o_rise,    1'b0);
        chk("rst_fall",  bus.o_fall,    1'b0);
        chk("rst_ready", bus.o_ready,   1'b0);
        chk("rst_ack",   bus.o_div_ack, 1'b0);
        chk("rst_err",   bus.o_div_err, 1'b0);
        cmp_en = 1;

        // Start at DEFAULT_DIV=4: cycle 0 is the first running cycle.
        rst = 1'b0;
        bus.i_enable = 1'b1;
        tick();
        now = 0;
        run_to(3);   chk("start_low_c3", bus.o_clk, 1'b0);
        run_to(4);   chk("first_rise_c4", bus.o_clk, 1'b1); chk("first_rise_flag", bus.o_rise, 1'b1);
        run_to(8);   chk("first_fall_c8", bus.o_clk, 1'b0); chk("first_fall_flag", bus.o_fall, 1'b1);
        run_to(123); chk("ready_c123", bus.o_ready, 1'b0);
        run_to(124); chk("ready_c124", bus.o_ready, 1'b1);

        // Illegal divisor: ack+err, period and ready untouched.
        run_to(125); req(1'b1, 8'd0);
        run_to(126); req(1'b0, 8'd0);
        chk("err_ack", bus.o_div_ack, 1'b1); chk("err_err", bus.o_div_err, 1'b1);
        run_to(127); chk("err_ack_pulse", bus.o_div_ack, 1'b0);
        run_to(128); chk("err_fall_c128", bus.o_fall, 1'b1); chk("err_ready_kept", bus.o_ready, 1'b1);
        run_to(132); chk("err_rise_c132", bus.o_rise, 1'b1);

        // Divisor 2 requested mid-high: high half finishes at 4, then 2/2.
        run_to(133); req(1'b1, 8'd2);
        run_to(134); req(1'b0, 8'd0);
        chk("div2_ack", bus.o_div_ack, 1'b1); chk("div2_err", bus.o_div_err, 1'b0);
        run_to(135); chk("div2_high_c135", bus.o_clk, 1'b1);
        run_to(136); chk("div2_fall_c136", bus.o_fall, 1'b1); chk("div2_ready_drop", bus.o_ready, 1'b0);
        run_to(138); chk("div2_rise_c138", bus.o_rise, 1'b1);
        run_to(140); chk("div2_fall_c140", bus.o_fall, 1'b1);
        run_to(197); chk("div2_ready_c197", bus.o_ready, 1'b0);
        run_to(198); chk("div2_ready_c198", bus.o_ready, 1'b1);

        // Back-to-back requests: the second waits for the first to apply.
        run_to(199); req(1'b1, 8'd4);
        run_to(200); req(1'b0, 8'd0); chk("dbl_ack1", bus.o_div_ack, 1'b1);
        run_to(201); req(1'b1, 8'd6);
        run_to(202); chk("dbl_hold_c202", bus.o_div_ack, 1'b0);
        run_to(204); chk("dbl_hold_c204", bus.o_div_ack, 1'b0); chk("dbl_apply_fall", bus.o_fall, 1'b1);
        run_to(205); req(1'b0, 8'd0); chk("dbl_ack2", bus.o_div_ack, 1'b1);
        run_to(208); chk("div4_rise_c208", bus.o_rise, 1'b1);
        run_to(212); chk("div4_fall_c212", bus.o_fall, 1'b1);
        run_to(217); chk("div6_low_c217", bus.o_clk, 1'b0);
        run_to(218); chk("div6_rise_c218", bus.o_rise, 1'b1);

        run_to(219); req(1'b1, 8'd4);
        run_to(220); req(1'b0, 8'd0); chk("div4b_ack", bus.o_div_ack, 1'b1);
        run_to(224); chk("div6_fall_c224", bus.o_fall, 1'b1);
        run_to(228); chk("div4b_rise_c228", bus.o_rise, 1'b1);

        // Stop right after a rise: high half completes, then output parks low.
        run_to(236); chk("stop_rise_c236", bus.o_rise, 1'b1);
        bus.i_enable = 1'b0;
        run_to(239); chk("stop_high_c239", bus.o_clk, 1'b1);
        run_to(240); chk("stop_fall_c240", bus.o_fall, 1'b1); chk("stop_ready", bus.o_ready, 1'b0);
        run_to(241); chk("stopped_rise", bus.o_rise, 1'b0); chk("stopped_fall", bus.o_fall, 1'b0);
        run_to(244); chk("stopped_clk", bus.o_clk, 1'b0);

        // Restart, then a brief enable dip mid-high that must not disturb o_clk.
        run_to(245); bus.i_enable = 1'b1;
        run_to(249); chk("restart_low_c249", bus.o_clk, 1'b0);
        run_to(250); chk("restart_rise_c250", bus.o_rise, 1'b1);
        run_to(251); bus.i_enable = 1'b0;
        run_to(252); bus.i_enable = 1'b1;
        run_to(254); chk("dip_fall_c254", bus.o_fall, 1'b1);
        run_to(258); chk("dip_rise_c258", bus.o_rise, 1'b1);

        // Reset mid-high with a pending divisor and a second request waiting.
        req(1'b1, 8'd3);
        run_to(259); req(1'b0, 8'd0); chk("rst_pend_ack", bus.o_div_ack, 1'b1);
        run_to(260); req(1'b1, 8'd5); rst = 1'b1;
        run_to(261);
        chk("midrst_clk", bus.o_clk, 1'b0);
        chk("midrst_ready", bus.o_ready, 1'b0);
        chk("midrst_ack", bus.o_div_ack, 1'b0);
        run_to(263); rst = 1'b0; req(1'b0, 8'd0);
        for (int i = 264; i <= 272; i++) begin
            run_to(i);
            chk("midrst_no_ack", bus.o_div_ack, 1'b0);
            if (i == 267) chk("midrst_low_c267", bus.o_clk, 1'b0);
            if (i == 268) chk("midrst_rise_c268", bus.o_rise, 1'b1);
            if (i == 272) chk("midrst_fall_c272", bus.o_fall, 1'b1);
        end

        run_to(280);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/xclk_ctrl.md
Name: xclk_ctrl

Overview:
- Controller for the camera master clock (XCLK): derives a divided square wave from the system clock.
- Divisor is programmable at run time through a req/ack handshake; changes take effect only on full-period boundaries, so no runt pulses reach the sensor.
- Start/stop is glitch-free and always leaves the output low.
- Raises o_ready once the output has run settled for a programmable number of periods; the SCCB config sequencer waits on o_ready before writing sensor registers.

Parameters:
- DIV_W, 8: width of divisor and half-period counter.
- DEFAULT_DIV, 4: divisor loaded at reset. Half-period = DEFAULT_DIV clk cycles. Must be 1..2^DIV_W-1.
- SETTLE_RISES, 16: o_clk rising edges required after start or divisor change before o_ready asserts. Must be ≥1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- i_enable  in  1  level; 1 = run o_clk, 0 = stop o_clk.
- i_div_req  in  1  level request to load i_div_val.
- i_div_val  in  DIV_W  requested divisor; half-period in clk cycles.
- o_div_ack  out  1  one-cycle pulse: request consumed.
- o_div_err  out  1  one-cycle pulse, coincident with ack: value rejected.
- o_clk  out  1  divided clock; registered output.
- o_rise  out  1  high in the cycle o_clk first reads 1.
- o_fall  out  1  high in the cycle o_clk first reads 0.
- o_ready  out  1  output settled at the current divisor.

Behaviour:
- Reset (sync, active-high): state=STOPPED, o_clk=0, cnt=1, div=DEFAULT_DIV, pending empty, settle count=0. All outputs 0. Reset mid-operation discards any pending divisor and ends any handshake with no ack.

Half-period counter:
- cnt counts 1..div.
- When running and cnt==div: toggle o_clk and set cnt<=1. Otherwise cnt<=cnt+1.
- Output period = 2*div cycles, 50% duty.
- Comparison is DIV_W wide. No wrap occurs because div ≥ 1.

States:
- STOPPED:
  - o_clk=0, cnt held at 1.
  - i_enable=1 → RUNNING.
  - First o_clk rise occurs div cycles after the first RUNNING cycle.
- RUNNING:
  - Counter active.
  - i_enable=0 with o_clk=0 → STOPPED next cycle; cnt<=1.
  - i_enable=0 with o_clk=1 → STOPPING.
- STOPPING:
  - Counter continues until the falling toggle, then → STOPPED.
  - i_enable back to 1 before the falling toggle → RUNNING with no disturbance to o_clk.

Divisor handshake:
- Acceptance: when i_div_req=1 and pending is empty, the block samples i_div_val and pulses o_div_ack the next cycle.
- Illegal value (i_div_val==0): o_div_err pulses with ack and the value is dropped.
- Legal value: stored as pending.
- Requester timing: i_div_req must be low in the cycle after ack. A request held high longer is treated as a new request.
- Request while pending is full: ack is withheld until the pending value is applied.
- Apply point, running or stopping: pending is applied in the cycle o_clk falls (cnt==div, o_clk=1).
  - The new div governs the following low half.
  - cnt<=1, pending cleared.
- Apply point, STOPPED: pending is applied in the cycle after ack.
- Apply and stop on the same falling toggle: both take effect; the next start uses the new div.

Settle / o_ready:
- Saturating rise counter increments on each o_rise.
- o_ready=1 when the count ≥ SETTLE_RISES.
- Counter is cleared, and o_ready drops in the same cycle, when entering STOPPED or when a divisor is applied.

Edge flags:
- o_rise and o_fall are registered alongside o_clk.
- They are never both high, and both are 0 while STOPPED.

Decomposition:
- Package xclk_pkg:
  - state enum (STOPPED, RUNNING, STOPPING);
  - localparam for the settle counter width, $clog2(SETTLE_RISES+1).
- Sub-module half_period_cnt: owns the counter, the toggle, and the rise/fall flags. Inputs: run, div, load. This is the existing divider function with enable and a programmable divisor.
- The handshake, FSM and settle logic stay in the top module.

Test Plan:
- Reset, then i_enable=1 at cycle 0 with DEFAULT_DIV=4 → o_clk=0 for cycles 0-3, rises at cycle 4, falls at cycle 8, period 8; o_ready rises at the 16th rise (cycle 124).
- Running div=4, i_div_req with 2 during the high half → ack the next cycle, err=0. Remaining high half stays 4 cycles. Then low 2 / high 2 cycles. o_ready drops at the apply cycle and reasserts 16 rises later.
- i_div_req with 0 → ack and err together for one cycle; period remains 8; o_ready unaffected.
- Second request while pending is full → no ack until the first value applies; second ack arrives the cycle after the apply.
- i_enable=0 one cycle after a rise at div=4 → o_clk stays high 3 more cycles, falls, then holds 0. Re-enable mid-high instead → waveform unchanged.
- Assert rst mid-high-phase with a pending divisor → next cycle o_clk=0, all outputs 0, div=4; no ack is ever issued for the discarded request.
